// File: rtl/dst_fifo_pkg.sv
// Shared definitions for the destination buffer and the write-back engine.
// Word width, tag width and default sizing live here so both sides agree.
package dst_fifo_pkg;

    localparam int DST_DW        = 64;
    localparam int DST_TW        = 1;
    localparam int DST_AW        = 5;
    localparam int DST_AF_MARGIN = 4;
    localparam int DST_AE_MARGIN = 2;

    typedef struct packed {
        logic [DST_TW-1:0] last;
        logic [DST_DW-1:0] data;
    } dst_word_t;

endpackage

// File: rtl/dst_fifo_if.sv
// Operation-stage put side and write-back get side of the destination buffer.
// The slave modport is the FIFO's view; master is the surrounding logic's view.
interface dst_fifo_if
    import dst_fifo_pkg::*;
#(
    parameter int AW = DST_AW
) ();

    logic              m_enable;
    logic              m_dst_putn;
    logic [DST_DW-1:0] m_dst;
    logic              m_dst_last;
    logic              m_endn;
    logic              m_dst_full;
    logic              m_dst_almost_full;
    logic              f_getn;
    logic [DST_DW-1:0] f_data;
    logic              f_last;
    logic              f_empty;
    logic              f_almost_empty;
    logic [AW:0]       f_count;
    logic              f_done;
    logic              f_ovf;
    logic              f_udf;

    modport slave (
        input  m_enable, m_dst_putn, m_dst, m_dst_last, m_endn, f_getn,
        output m_dst_full, m_dst_almost_full, f_data, f_last, f_empty,
               f_almost_empty, f_count, f_done, f_ovf, f_udf
    );

    modport master (
        output m_enable, m_dst_putn, m_dst, m_dst_last, m_endn, f_getn,
        input  m_dst_full, m_dst_almost_full, f_data, f_last, f_empty,
               f_almost_empty, f_count, f_done, f_ovf, f_udf
    );

endinterface

// File: rtl/dst_fifo_ram.sv
// Simple dual-port word store with synchronous write and enable-gated registered read.
// Only the read register is reset so the array itself still maps onto RAM primitives.
module dst_fifo_ram
    import dst_fifo_pkg::*;
#(
    parameter int AW = DST_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  dst_word_t     wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output dst_word_t     rdata
);

    dst_word_t mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dst_fifo.sv
// Destination buffer between the DMA operation stage and write-back.
// Holds pointer, status-flag and end-of-operation logic around dst_fifo_ram.
module dst_fifo
    import dst_fifo_pkg::*;
#(
    parameter int AW        = DST_AW,
    parameter int AF_MARGIN = DST_AF_MARGIN,
    parameter int AE_MARGIN = DST_AE_MARGIN
) (
    input logic       wb_clk_i,
    input logic       wb_rst_i,
    dst_fifo_if.slave bus
);

    localparam logic [AW:0] DEPTH    = (AW+1)'(2**AW);
    localparam logic [AW:0] AF_LEVEL = (AW+1)'(2**AW - AF_MARGIN);
    localparam logic [AW:0] AE_LEVEL = (AW+1)'(AE_MARGIN);

    logic [AW:0] wptr, rptr;
    logic [AW:0] wptr_nxt, rptr_nxt, count_nxt;
    logic        full_now, empty_now;
    logic        wr_acc, rd_acc;
    logic        end_seen, end_seen_nxt;
    dst_word_t   wr_word, rd_word;

    // Acceptance uses the live pointers; a full write or empty read is dropped
    // regardless of what the other side does in the same cycle.
    always_comb begin
        full_now     = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
        empty_now    = (wptr == rptr);
        wr_acc       = !bus.m_dst_putn && !full_now;
        rd_acc       = !bus.f_getn && !empty_now;
        wptr_nxt     = wptr + {{AW{1'b0}}, wr_acc};
        rptr_nxt     = rptr + {{AW{1'b0}}, rd_acc};
        count_nxt    = wptr_nxt - rptr_nxt;
        end_seen_nxt = bus.m_enable && (end_seen || !bus.m_endn);
        wr_word.last = bus.m_dst_last;
        wr_word.data = bus.m_dst;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wptr                  <= '0;
            rptr                  <= '0;
            end_seen              <= 1'b0;
            bus.m_dst_full        <= 1'b0;
            bus.m_dst_almost_full <= 1'b0;
            bus.f_empty           <= 1'b1;
            bus.f_almost_empty    <= 1'b1;
            bus.f_count           <= '0;
            bus.f_done            <= 1'b0;
            bus.f_ovf             <= 1'b0;
            bus.f_udf             <= 1'b0;
        end else begin
            wptr                  <= wptr_nxt;
            rptr                  <= rptr_nxt;
            end_seen              <= end_seen_nxt;
            // Flags come from next-state pointers so they are exact right after the edge.
            bus.m_dst_full        <= (count_nxt == DEPTH);
            bus.m_dst_almost_full <= (count_nxt >= AF_LEVEL);
            bus.f_empty           <= (count_nxt == '0);
            bus.f_almost_empty    <= (count_nxt <= AE_LEVEL);
            bus.f_count           <= count_nxt;
            bus.f_done            <= end_seen_nxt && (count_nxt == '0) && !wr_acc;
            if (!bus.m_dst_putn && full_now) begin
                bus.f_ovf <= 1'b1;
            end
            if (!bus.f_getn && empty_now) begin
                bus.f_udf <= 1'b1;
            end
        end
    end

    // Read and write addresses only coincide when empty or full, and then one
    // side is always blocked, so no read-during-write hazard exists.
    dst_fifo_ram #(
        .AW(AW)
    ) u_ram (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .we    (wr_acc && !wb_rst_i),
        .waddr (wptr[AW-1:0]),
        .wdata (wr_word),
        .re    (rd_acc),
        .raddr (rptr[AW-1:0]),
        .rdata (rd_word)
    );

    assign bus.f_data = rd_word.data;
    assign bus.f_last = rd_word.last;

endmodule

// File: tb/tb_dst_fifo.sv
// Self-checking bench for dst_fifo: directed scenarios plus a random stream,
// all compared every cycle against a queue-based reference model.
module tb_dst_fifo;
    import dst_fifo_pkg::*;

    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic wb_clk_i = 1'b0;
    logic wb_rst_i;

    dst_fifo_if #(.AW(AW)) bus ();

    dst_fifo #(
        .AW        (AW),
        .AF_MARGIN (4),
        .AE_MARGIN (2)
    ) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .bus      (bus)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    logic [64:0] mdl_q[$];
    logic [63:0] mdl_data;
    logic        mdl_last, mdl_ovf, mdl_udf, mdl_end_seen, mdl_done;
    int          checks = 0;
    int          errors = 0;
    int          written;
    logic        en;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll();
        int n;
        n = mdl_q.size();
        checkOutput("count",        64'(bus.f_count),           64'(n));
        checkOutput("full",         64'(bus.m_dst_full),        64'(n == DEPTH));
        checkOutput("almost_full",  64'(bus.m_dst_almost_full), 64'(n >= DEPTH - 4));
        checkOutput("empty",        64'(bus.f_empty),           64'(n == 0));
        checkOutput("almost_empty", 64'(bus.f_almost_empty),   64'(n <= 2));
        checkOutput("data",         bus.f_data,                 mdl_data);
        checkOutput("last",         64'(bus.f_last),            64'(mdl_last));
        checkOutput("done",         64'(bus.f_done),            64'(mdl_done));
        checkOutput("ovf",          64'(bus.f_ovf),             64'(mdl_ovf));
        checkOutput("udf",          64'(bus.f_udf),             64'(mdl_udf));
    endtask

    // One clock: drive inputs, advance the model across the edge, then compare.
    task automatic applyStimulus(input logic rst, input logic enable, input logic putn,
                                 input logic [63:0] data, input logic last,
                                 input logic getn, input logic endn);
        int   n;
        logic wr, rd;
        wb_rst_i       = rst;
        bus.m_enable   = enable;
        bus.m_dst_putn = putn;
        bus.m_dst      = data;
        bus.m_dst_last = last;
        bus.f_getn     = getn;
        bus.m_endn     = endn;
        @(posedge wb_clk_i);
        if (rst) begin
            mdl_q.delete();
            mdl_data     = '0;
            mdl_last     = 1'b0;
            mdl_ovf      = 1'b0;
            mdl_udf      = 1'b0;
            mdl_end_seen = 1'b0;
            mdl_done     = 1'b0;
        end else begin
            n  = mdl_q.size();
            wr = !putn && (n < DEPTH);
            rd = !getn && (n > 0);
            if (!putn && n == DEPTH) mdl_ovf = 1'b1;
            if (!getn && n == 0)     mdl_udf = 1'b1;
            if (rd) {mdl_last, mdl_data} = mdl_q.pop_front();
            if (wr) mdl_q.push_back({last, data});
            if (!enable)   mdl_end_seen = 1'b0;
            else if (!endn) mdl_end_seen = 1'b1;
            mdl_done = mdl_end_seen && (mdl_q.size() == 0) && !wr;
        end
        #1;
        checkAll();
    endtask

    task automatic putWord(input logic [63:0] data, input logic last);
        applyStimulus(1'b0, en, 1'b0, data, last, 1'b1, 1'b1);
    endtask

    task automatic getWord();
        applyStimulus(1'b0, en, 1'b1, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, en, 1'b1, '0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        logic        putn, getn;
        logic [63:0] rdata;

        en = 1'b1;
        mdl_data = '0; mdl_last = 0; mdl_ovf = 0; mdl_udf = 0;
        mdl_end_seen = 0; mdl_done = 0;
        doReset();
        doReset();
        checkOutput("reset_empty", 64'(bus.f_empty), 64'd1);

        // Fill to full, then one put too many.
        for (int i = 1; i <= DEPTH; i++) putWord(64'(i), 1'b0);
        checkOutput("fill_full", 64'(bus.m_dst_full), 64'd1);
        putWord(64'h21, 1'b0);
        checkOutput("fill_ovf", 64'(bus.f_ovf), 64'd1);

        // Drain everything, then one read too many.
        for (int i = 1; i <= DEPTH; i++) begin
            getWord();
            checkOutput("drain_order", bus.f_data, 64'(i));
        end
        getWord();
        checkOutput("drain_udf", 64'(bus.f_udf), 64'd1);
        checkOutput("drain_hold", bus.f_data, 64'h20);

        // Random 100-word stream; pointers wrap several times.
        doReset();
        written = 0;
        for (int cyc = 0; cyc < 3000 && (written < 100 || mdl_q.size() > 0); cyc++) begin
            putn  = (written < 100) ? 1'($urandom_range(0, 1)) : 1'b1;
            getn  = 1'($urandom_range(0, 1));
            rdata = {$urandom, $urandom};
            if (!putn && mdl_q.size() < DEPTH) written++;
            applyStimulus(1'b0, en, putn, rdata, rdata[0], getn, 1'b1);
        end
        checkOutput("stream_written", 64'(written), 64'd100);
        checkOutput("stream_drained", 64'(bus.f_empty), 64'd1);

        // Simultaneous put and get at half, empty and full occupancy.
        doReset();
        for (int i = 0; i < 16; i++) putWord(64'(i + 100), 1'b0);
        applyStimulus(1'b0, en, 1'b0, 64'h55, 1'b0, 1'b0, 1'b1);
        checkOutput("sim16_count", 64'(bus.f_count), 64'd16);
        for (int i = 0; i < 16; i++) getWord();
        applyStimulus(1'b0, en, 1'b0, 64'h66, 1'b0, 1'b0, 1'b1);
        checkOutput("sim0_udf", 64'(bus.f_udf), 64'd1);
        checkOutput("sim0_count", 64'(bus.f_count), 64'd1);
        doReset();
        for (int i = 0; i < DEPTH; i++) putWord(64'(i + 200), 1'b0);
        applyStimulus(1'b0, en, 1'b0, 64'h77, 1'b0, 1'b0, 1'b1);
        checkOutput("sim32_ovf", 64'(bus.f_ovf), 64'd1);
        checkOutput("sim32_count", 64'(bus.f_count), 64'd31);

        // End-of-operation tracking.
        doReset();
        en = 1'b1;
        putWord(64'hA1, 1'b0);
        putWord(64'hA2, 1'b0);
        putWord(64'hA3, 1'b1);
        applyStimulus(1'b0, en, 1'b1, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("done_before_drain", 64'(bus.f_done), 64'd0);
        getWord();
        getWord();
        checkOutput("done_partial", 64'(bus.f_done), 64'd0);
        getWord();
        checkOutput("done_set", 64'(bus.f_done), 64'd1);
        checkOutput("done_last", 64'(bus.f_last), 64'd1);
        en = 1'b0;
        applyStimulus(1'b0, en, 1'b1, '0, 1'b0, 1'b1, 1'b1);
        checkOutput("done_clear", 64'(bus.f_done), 64'd0);
        en = 1'b1;

        // Reset with words buffered discards them.
        for (int i = 0; i < 10; i++) putWord(64'(i + 300), 1'b0);
        doReset();
        checkOutput("midrst_count", 64'(bus.f_count), 64'd0);
        checkOutput("midrst_data", bus.f_data, 64'd0);
        putWord(64'hABC, 1'b0);
        getWord();
        checkOutput("midrst_newdata", bus.f_data, 64'hABC);
        checkOutput("midrst_empty", 64'(bus.f_empty), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
